// File: rtl/aes_axis_pkg.sv
// Shared widths and types for the AES AXI-Stream width converters.
// Used by both the 512-to-128 read path and the 128-to-512 write path.
package aes_axis_pkg;

  localparam int AXIS_WIDTH = 128;
  localparam int MEM_WIDTH  = 512;
  localparam int LANES      = MEM_WIDTH / AXIS_WIDTH;
  localparam int LANE_W     = $clog2(LANES);

  typedef logic [AXIS_WIDTH-1:0] aes_block_t;
  typedef logic [MEM_WIDTH-1:0]  mem_word_t;

endpackage

// File: rtl/axis_dwidth_512to128.sv
// Splits each 512-bit word into four 128-bit beats; first beat one cycle after accept.
// Next word is taken during the last beat's handshake, so full-rate streaming has no bubbles.
module axis_dwidth_512to128
  import aes_axis_pkg::*;
#(
  parameter int MSB_LANE_FIRST = 0,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  mem_word_t            s_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output aes_block_t           m_tdata,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic                 idle
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  mem_word_t            buf_q, buf_d;
  logic                 full_q, full_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [LANE_W-1:0]    sel_lane;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 fire;
  logic                 accept;

  assign fire     = full_q && m_tready;
  assign s_tready = !areset && (!full_q || ((lane_q == LAST_LANE) && m_tready));
  assign accept   = s_tvalid && s_tready;

  always_comb begin
    buf_d      = buf_q;
    full_d     = full_q;
    lane_d     = lane_q;
    word_cnt_d = word_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if (fire) begin
      lane_d     = lane_q + LANE_W'(1);
      beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
      if (lane_q == LAST_LANE) begin
        full_d = 1'b0;
      end
    end
    // An accept only happens when empty or on the last beat, so it overrides the fire update.
    if (accept) begin
      buf_d      = s_tdata;
      full_d     = 1'b1;
      lane_d     = '0;
      word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      full_q     <= 1'b0;
      lane_q     <= '0;
      word_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      full_q     <= full_d;
      lane_q     <= lane_d;
      word_cnt_q <= word_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Data buffer needs no reset; it is only observed while full_q is set.
  always_ff @(posedge aclk) begin
    buf_q <= buf_d;
  end

  assign sel_lane = (MSB_LANE_FIRST != 0) ? (LAST_LANE - lane_q) : lane_q;

  always_comb begin
    m_tdata = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sel_lane == LANE_W'(i)) begin
        m_tdata = buf_q[i*AXIS_WIDTH +: AXIS_WIDTH];
      end
    end
  end

  assign m_tvalid = full_q;
  assign word_cnt = word_cnt_q;
  assign beat_cnt = beat_cnt_q;
  assign idle     = !full_q && !s_tvalid;

endmodule

// File: tb/tb_axis_dwidth_512to128.sv
// Drives an LSB-first and an MSB-first converter with shared stimulus against a beat-queue model.
module tb_axis_dwidth_512to128;
  import aes_axis_pkg::*;

  logic       aclk = 1'b0;
  logic       areset;
  logic       s_tvalid;
  logic       m_tready;
  mem_word_t  s_tdata;

  logic       s_tready0, s_tready1;
  logic       m_tvalid0, m_tvalid1;
  logic       idle0, idle1;
  aes_block_t m_tdata0, m_tdata1;
  logic [31:0] word_cnt0, beat_cnt0;
  logic [2:0]  word_cnt1, beat_cnt1;

  always #5 aclk = ~aclk;

  axis_dwidth_512to128 #(.MSB_LANE_FIRST(0), .CNT_WIDTH(32)) dut0 (
    .aclk(aclk), .areset(areset),
    .s_tvalid(s_tvalid), .s_tready(s_tready0), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid0), .m_tready(m_tready), .m_tdata(m_tdata0),
    .word_cnt(word_cnt0), .beat_cnt(beat_cnt0), .idle(idle0)
  );

  axis_dwidth_512to128 #(.MSB_LANE_FIRST(1), .CNT_WIDTH(3)) dut1 (
    .aclk(aclk), .areset(areset),
    .s_tvalid(s_tvalid), .s_tready(s_tready1), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid1), .m_tready(m_tready), .m_tdata(m_tdata1),
    .word_cnt(word_cnt1), .beat_cnt(beat_cnt1), .idle(idle1)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: pending beats in emit order for each lane ordering.
  aes_block_t  q0[$];
  aes_block_t  q1[$];
  int unsigned words_m = 0;
  int unsigned beats_m = 0;
  logic        exp_rdy;
  int          obs_acc = 0;
  int          obs_vld_low = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mem_word_t rand_word();
    mem_word_t w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic aes_block_t lane_of(input mem_word_t w, input int i);
    return w[i*AXIS_WIDTH +: AXIS_WIDTH];
  endfunction

  // Check outputs mid-cycle, then advance the model across the next rising edge.
  task automatic cycle();
    logic exp_vld;
    logic exp_idle;
    logic [31:0] wm;
    logic [31:0] bm;
    @(negedge aclk);
    exp_vld  = (q0.size() != 0);
    exp_rdy  = !areset && ((q0.size() == 0) || ((q0.size() == 1) && m_tready));
    exp_idle = !exp_vld && !s_tvalid;
    wm = words_m;
    bm = beats_m;
    check("s_tready",      s_tready0, exp_rdy);
    check("s_tready_rev",  s_tready1, exp_rdy);
    check("m_tvalid",      m_tvalid0, exp_vld);
    check("m_tvalid_rev",  m_tvalid1, exp_vld);
    check("idle",          idle0, exp_idle);
    check("idle_rev",      idle1, exp_idle);
    check("word_cnt",      word_cnt0, wm);
    check("beat_cnt",      beat_cnt0, bm);
    check("word_cnt_wrap", word_cnt1, wm[2:0]);
    check("beat_cnt_wrap", beat_cnt1, bm[2:0]);
    if (exp_vld) begin
      check("m_tdata",     m_tdata0, q0[0]);
      check("m_tdata_rev", m_tdata1, q1[0]);
    end
    if (s_tvalid && s_tready0) obs_acc++;
    if (!m_tvalid0) obs_vld_low++;
    @(posedge aclk);
    #1;
    if (areset) begin
      q0.delete();
      q1.delete();
      words_m = 0;
      beats_m = 0;
    end else begin
      if (exp_vld && m_tready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        beats_m++;
      end
      if (s_tvalid && exp_rdy) begin
        for (int i = 0; i < LANES; i++) q0.push_back(lane_of(s_tdata, i));
        for (int i = LANES - 1; i >= 0; i--) q1.push_back(lane_of(s_tdata, i));
        words_m++;
      end
    end
  endtask

  mem_word_t w, w2;
  int prev_acc;

  initial begin
    areset   = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    s_tdata  = '0;
    repeat (2) @(posedge aclk);
    #1;
    cycle();
    cycle();
    areset = 1'b0;
    cycle();

    // Single word, lane order in both instances
    w = {128'hD, 128'hC, 128'hB, 128'hA};
    s_tdata  = w;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    cycle();
    s_tvalid = 1'b0;
    check("single_first_beat",     m_tdata0, 128'hA);
    check("single_first_beat_rev", m_tdata1, 128'hD);
    check("single_latency_vld",    m_tvalid0, 1'b1);
    repeat (4) cycle();
    check("single_word_cnt", word_cnt0, 32'd1);
    check("single_beat_cnt", beat_cnt0, 32'd4);
    check("single_idle",     idle0, 1'b1);

    // Streaming eight words back to back
    s_tdata  = rand_word();
    s_tvalid = 1'b1;
    obs_acc  = 0;
    cycle();
    s_tdata = rand_word();
    obs_vld_low = 0;
    for (int c = 1; c <= 32; c++) begin
      prev_acc = obs_acc;
      cycle();
      if (obs_acc != prev_acc) begin
        if (obs_acc >= 8) s_tvalid = 1'b0;
        else s_tdata = rand_word();
      end
    end
    check("stream_accepts",  obs_acc, 8);
    check("stream_vld_gaps", obs_vld_low, 0);
    cycle();

    // Backpressure at lane 2, then last-beat fire with simultaneous accept
    w = rand_word();
    s_tdata  = w;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    cycle();
    s_tvalid = 1'b0;
    cycle();
    cycle();
    check("bp_lane2", m_tdata0, lane_of(w, 2));
    w2 = rand_word();
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = w2;
    repeat (5) begin
      cycle();
      check("bp_hold",     m_tdata0, lane_of(w, 2));
      check("bp_hold_rev", m_tdata1, lane_of(w, 1));
      check("bp_s_tready", s_tready0, 1'b0);
    end
    m_tready = 1'b1;
    cycle();
    cycle();
    check("simul_full",      m_tvalid0, 1'b1);
    check("simul_lane0",     m_tdata0, lane_of(w2, 0));
    check("simul_lane0_rev", m_tdata1, lane_of(w2, 3));
    s_tvalid = 1'b0;
    repeat (4) cycle();

    // Reset after two beats of a word
    w = {128'hD, 128'hC, 128'hB, 128'hA};
    s_tdata  = w;
    s_tvalid = 1'b1;
    cycle();
    s_tvalid = 1'b0;
    cycle();
    cycle();
    areset   = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = rand_word();
    cycle();
    check("rst_m_tvalid", m_tvalid0, 1'b0);
    check("rst_word_cnt", word_cnt0, 32'd0);
    check("rst_beat_cnt", beat_cnt0, 32'd0);
    check("rst_s_tready", s_tready0, 1'b0);
    cycle();
    areset = 1'b0;
    w = rand_word();
    s_tdata = w;
    cycle();
    s_tvalid = 1'b0;
    check("post_rst_lane0",     m_tdata0, lane_of(w, 0));
    check("post_rst_lane0_rev", m_tdata1, lane_of(w, 3));
    check("post_rst_word_cnt",  word_cnt0, 32'd1);
    repeat (4) cycle();

    // Random traffic with occasional resets; exercises the 3-bit counter wrap
    for (int c = 0; c < 400; c++) begin
      m_tready = ($urandom_range(0, 3) != 0);
      s_tvalid = ($urandom_range(0, 1) != 0);
      areset   = ($urandom_range(0, 99) == 0);
      s_tdata  = rand_word();
      cycle();
    end
    areset   = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (5) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_dwidth_512to128.md
# axis_dwidth_512to128

Width down-converter between the kernel's 512-bit AXI memory read path and the 128-bit AES block stream. It accepts one 512-bit word per handshake and emits it as four 128-bit beats in a fixed lane order. It sits directly upstream of the AES engine input, and its master side connects to an `axis_if.MASTER` modport at the parent. Sustained throughput is one 128-bit beat per cycle with no bubbles.

## Interface

Parameters:
- `MSB_LANE_FIRST`, default 0. If 0, the emit order is bits [127:0], [255:128], [383:256], [511:384]. If 1, the order is reversed.
- `CNT_WIDTH`, default 32. Width of the beat and word status counters.

Ports:
- Clock and reset: one clock, `aclk`. Reset `areset` is synchronous and active-high.
- `aclk` in 1: sole clock; all logic on the rising edge.
- `areset` in 1: synchronous, active-high reset.
- `s_tvalid` in 1: upstream 512-bit word valid.
- `s_tready` out 1: this block can accept a 512-bit word.
- `s_tdata` in 512: upstream word.
- `m_tvalid` out 1: 128-bit beat valid; maps to `axis_if.tvalid`.
- `m_tready` in 1: downstream ready; maps to `axis_if.tready`.
- `m_tdata` out 128: current beat; maps to `axis_if.tdata`.
- `word_cnt` out CNT_WIDTH: count of accepted 512-bit words.
- `beat_cnt` out CNT_WIDTH: count of emitted 128-bit beats.
- `idle` out 1: high when the buffer is empty and `s_tvalid` is low.

## Operation

State:
- `buf` (512 b)
- `full` (1 b)
- `lane` (2 b, 0..3)
- the two counters

Rules:
- **Output drive.** `m_tvalid` = `full`. `m_tdata` = lane-selected slice of `buf`. The lane index is `lane` if `MSB_LANE_FIRST`=0, else 3−`lane`. This is a mux from registers only, with no combinational path from `s_*`.
- **Beat fire.** A beat fires when `m_tvalid` && `m_tready`. Then `lane` increments and `beat_cnt` increments.
- **Last lane.** On a fire at `lane`==3, `lane` wraps to 0.
- **Input acceptance.** `s_tready` = !`areset` && (!`full` || (`lane`==3 && `m_tready`)). An accept is `s_tvalid` && `s_tready`. It loads `buf`, sets `full`=1, sets `lane`=0 and increments `word_cnt`.
- **Simultaneous last-beat fire and accept.** The new word loads, `full` stays 1 and `lane` goes 0. This is a back-to-back word with no bubble.
- **Last-beat fire, no accept.** `full` clears to 0.
- **Stall.** With `m_tready` low and `m_tvalid` high, `m_tdata` and `lane` hold stable. AXI-S rule: once asserted, `m_tvalid` is never withdrawn until the beat fires.
- **Counter wrap.** Counters wrap modulo 2^CNT_WIDTH, with no saturation.
- **Reset mid-operation.** `areset` discards any partially emitted word; remaining lanes are lost. The next word starts at lane 0.

## Timing

Reset values, applied on the cycle after `areset` is sampled high:
- `full`=0, so `m_tvalid`=0
- `lane`=0
- `word_cnt`=0, `beat_cnt`=0
- `m_tdata` = slice of `buf`; `buf` content is don't-care and is not reset

During reset:
- `s_tready`=0 while `areset` is high.
- `idle` = !`full` && !`s_tvalid`.

Latency:
- An accept at edge N gives `m_tvalid`=1 with lane 0 data on cycle N+1.
- Lane 3 is emitted at N+4 if `m_tready` stays high.

Throughput:
- With `s_tvalid` and `m_tready` both constantly high, one 512-bit word is accepted every 4 cycles.
- `m_tvalid` stays continuously high.

Backpressure:
- With `m_tready` low and the block full, `s_tready` is low.

## Structure

- **Shared package `aes_axis_pkg`.** Holds `AXIS_WIDTH`=128, `MEM_WIDTH`=512, `LANES`=MEM_WIDTH/AXIS_WIDTH, and typedefs `aes_block_t` (logic [127:0]) and `mem_word_t` (logic [511:0]).
- **Lane counter width.** Derived as $clog2(LANES).
- **No sub-module.** The block is a single module. Parent glue ties the `m_*` ports to an `axis_if` instance.
- **Companion block.** The 128-to-512 up-converter on the write path reuses the same package.

## Test plan

1. **Single word.** After reset, drive `s_tdata` = {128'hD, 128'hC, 128'hB, 128'hA} for one cycle with `m_tready`=1. Required: beats A, B, C, D on consecutive cycles starting at N+1; then `word_cnt`=1, `beat_cnt`=4, `idle`=1.
2. **Streaming.** Drive 8 consecutive words with `s_tvalid` and `m_tready` high. Required: 32 beats with `m_tvalid` never low between the first and last beat, and `s_tready` high exactly once per 4 cycles.
3. **Backpressure.** Hold `m_tready`=0 for 5 cycles mid-word at lane 2. Required: `m_tdata` stays at lane 2 data, `s_tready`=0, and no beat or word lost.
4. **Simultaneous events.** At `lane`==3 with `m_tready`=1 and `s_tvalid`=1, the next cycle shows the new word's lane 0 with `full` still 1.
5. **Reset mid-word.** Assert `areset` after 2 beats of word {A,B,C,D}. Required: `m_tvalid`=0, counters 0, `s_tready`=0 during reset. After release, a new word emits from lane 0.
6. **Lane order.** With `MSB_LANE_FIRST`=1, drive the word from scenario 1. Required: output order is D, C, B, A.
